// File: rtl/mips_harvard_mem.sv
// mips_harvard_mem: instruction and data memory for the memory side of a
// Harvard MIPS CPU. The program is loaded word-by-word through the init port,
// after which the CPU runs with combinational reads and edge-committed stores.
// Any illegal access parks the block in a sticky FAULT state until reset.
module mips_harvard_mem #(
    parameter int          INSTR_WORDS  = 256,
    parameter int          DATA_WORDS   = 256,
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] DATA_BASE    = 32'h00000000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           init_mem,
    input  logic [31:0]                    init_mem_addr,
    input  logic [31:0]                    init_instr,
    output logic                           clk_enable,
    output logic                           instr_active,
    input  logic [31:0]                    instr_address,
    output logic [31:0]                    instr_readdata,
    input  logic [31:0]                    data_address,
    input  logic                           data_read,
    input  logic                           data_write,
    input  logic [31:0]                    data_writedata,
    output logic [31:0]                    data_readdata,
    output logic [$clog2(INSTR_WORDS):0]   load_count,
    output logic                           fault,
    output logic [31:0]                    fault_addr
);

    localparam int IW = $clog2(INSTR_WORDS);
    localparam int DW = $clog2(DATA_WORDS);
    localparam int CW = IW + 1;

    localparam logic [CW-1:0] COUNT_MAX = CW'(INSTR_WORDS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    logic [31:0] imem [INSTR_WORDS];
    logic [31:0] dmem [DATA_WORDS];

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] load_count_q, load_count_d;
    logic [31:0]   fault_addr_q, fault_addr_d;

    logic          imem_we;
    logic          dmem_we;

    // Word offsets from each region base; modulo-2^32 subtraction means an
    // address below the base wraps to a huge offset and fails the depth test.
    logic [31:0] i_word, d_word, l_word;
    logic        i_ok, d_ok, l_ok;
    logic [IW-1:0] i_idx, l_idx;
    logic [DW-1:0] d_idx;
    logic        run;

    assign i_word = (instr_address - RESET_VECTOR) >> 2;
    assign d_word = (data_address  - DATA_BASE)    >> 2;
    assign l_word = (init_mem_addr - RESET_VECTOR) >> 2;

    assign i_ok = (i_word < 32'(INSTR_WORDS)) && (instr_address[1:0] == 2'b00);
    assign d_ok = (d_word < 32'(DATA_WORDS))  && (data_address[1:0]  == 2'b00);
    assign l_ok = (l_word < 32'(INSTR_WORDS)) && (init_mem_addr[1:0] == 2'b00);

    assign i_idx = i_word[IW-1:0];
    assign d_idx = d_word[DW-1:0];
    assign l_idx = l_word[IW-1:0];

    assign run = (state_q == ST_RUN);

    // Next-state, load counting, fault capture and write-enable decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d      = state_q;
        load_count_d = load_count_q;
        fault_addr_d = fault_addr_q;
        imem_we      = 1'b0;
        dmem_we      = 1'b0;
        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (init_mem) begin
                    if (l_ok) begin
                        imem_we = 1'b1;
                        state_d = ST_LOAD;
                        if (load_count_q < COUNT_MAX) begin
                            load_count_d = load_count_q + 1'b1;
                        end
                    end else begin
                        state_d      = ST_FAULT;
                        fault_addr_d = init_mem_addr;
                    end
                end else if (state_q == ST_LOAD) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Priority order: read+write clash, bad data access, bad fetch.
                if (data_read && data_write) begin
                    state_d      = ST_FAULT;
                    fault_addr_d = data_address;
                end else if ((data_read || data_write) && !d_ok) begin
                    state_d      = ST_FAULT;
                    fault_addr_d = data_address;
                end else if (!i_ok) begin
                    state_d      = ST_FAULT;
                    fault_addr_d = instr_address;
                end else if (data_write) begin
                    dmem_we = 1'b1;
                end
            end
            default: ;  // FAULT is terminal; everything holds.
        endcase
    end

    // Control state; cleared asynchronously on reset.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset) begin
            state_q      <= ST_IDLE;
            load_count_q <= '0;
            fault_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            load_count_q <= load_count_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    // Memory arrays: writes only, contents survive reset.
    always_ff @(posedge clk) begin
        // NOTE: the arrays deliberately have no reset branch; a reset loop
        // over every word would turn the RAMs into flop arrays.
        if (imem_we) begin
            imem[l_idx] <= init_instr;
        end
        if (dmem_we) begin
            dmem[d_idx] <= data_writedata;
        end
    end

    assign clk_enable     = run;
    assign instr_active   = run;
    assign fault          = (state_q == ST_FAULT);
    assign fault_addr     = fault_addr_q;
    assign load_count     = load_count_q;
    assign instr_readdata = (run && i_ok) ? imem[i_idx] : 32'h0;
    assign data_readdata  = (run && data_read && d_ok) ? dmem[d_idx] : 32'h0;

endmodule

// File: tb/tb_mips_harvard_mem.sv
// Self-checking bench for mips_harvard_mem: a behavioural model tracks the
// memories and phase, a compare process checks every output each negedge, and
// directed scenarios add literal expectations around randomized RUN traffic.
module tb_mips_harvard_mem;

    localparam logic [31:0] RV = 32'hBFC00000;
    localparam logic [31:0] DB = 32'h00000000;
    localparam int          IWORDS = 256;
    localparam int          DWORDS = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        init_mem = 1'b0;
    logic [31:0] init_mem_addr = RV;
    logic [31:0] init_instr = 32'h0;
    logic        clk_enable;
    logic        instr_active;
    logic [31:0] instr_address = RV;
    logic [31:0] instr_readdata;
    logic [31:0] data_address = DB;
    logic        data_read = 1'b0;
    logic        data_write = 1'b0;
    logic [31:0] data_writedata = 32'h0;
    logic [31:0] data_readdata;
    logic [8:0]  load_count;
    logic        fault;
    logic [31:0] fault_addr;

    mips_harvard_mem #(
        .INSTR_WORDS (IWORDS),
        .DATA_WORDS  (DWORDS),
        .RESET_VECTOR(RV),
        .DATA_BASE   (DB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .init_mem      (init_mem),
        .init_mem_addr (init_mem_addr),
        .init_instr    (init_instr),
        .clk_enable    (clk_enable),
        .instr_active  (instr_active),
        .instr_address (instr_address),
        .instr_readdata(instr_readdata),
        .data_address  (data_address),
        .data_read     (data_read),
        .data_write    (data_write),
        .data_writedata(data_writedata),
        .data_readdata (data_readdata),
        .load_count    (load_count),
        .fault         (fault),
        .fault_addr    (fault_addr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_LOAD, M_RUN, M_FAULT} phase_t;
    phase_t      m_phase = M_IDLE;
    int          m_count = 0;
    logic [31:0] m_faddr = 32'h0;
    logic [31:0] m_imem [IWORDS];
    bit          m_iv   [IWORDS];
    logic [31:0] m_dmem [DWORDS];
    bit          m_dv   [DWORDS];

    function automatic bit m_ok(input logic [31:0] a, input logic [31:0] base, input int depth);
        logic [31:0] off;
        off = a - base;
        return ((off / 32'd4) < 32'(depth)) && ((a % 32'd4) == 32'd0);
    endfunction

    function automatic int m_idx(input logic [31:0] a, input logic [31:0] base);
        logic [31:0] off;
        off = a - base;
        return int'(off / 32'd4);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase = M_IDLE;
            m_count = 0;
            m_faddr = 32'h0;
        end else begin
            case (m_phase)
                M_IDLE, M_LOAD: begin
                    if (init_mem) begin
                        if (m_ok(init_mem_addr, RV, IWORDS)) begin
                            m_imem[m_idx(init_mem_addr, RV)] = init_instr;
                            m_iv[m_idx(init_mem_addr, RV)]   = 1'b1;
                            if (m_count < IWORDS) m_count++;
                            m_phase = M_LOAD;
                        end else begin
                            m_phase = M_FAULT;
                            m_faddr = init_mem_addr;
                        end
                    end else if (m_phase == M_LOAD) begin
                        m_phase = M_RUN;
                    end
                end
                M_RUN: begin
                    if ((data_read && data_write) ||
                        ((data_read || data_write) && !m_ok(data_address, DB, DWORDS))) begin
                        m_phase = M_FAULT;
                        m_faddr = data_address;
                    end else if (!m_ok(instr_address, RV, IWORDS)) begin
                        m_phase = M_FAULT;
                        m_faddr = instr_address;
                    end else if (data_write) begin
                        m_dmem[m_idx(data_address, DB)] = data_writedata;
                        m_dv[m_idx(data_address, DB)]   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Compare process: every output against the model, mid-cycle.
    bit started = 1'b0;
    always @(negedge clk) begin
        if (started) begin
            check("clk_enable",   32'(clk_enable),   32'(m_phase == M_RUN));
            check("instr_active", 32'(instr_active), 32'(m_phase == M_RUN));
            check("fault",        32'(fault),        32'(m_phase == M_FAULT));
            check("fault_addr",   fault_addr,        m_faddr);
            check("load_count",   32'(load_count),   32'(m_count));
            if (m_phase == M_RUN && m_ok(instr_address, RV, IWORDS)) begin
                if (m_iv[m_idx(instr_address, RV)])
                    check("instr_readdata", instr_readdata, m_imem[m_idx(instr_address, RV)]);
            end else begin
                check("instr_readdata_zero", instr_readdata, 32'h0);
            end
            if (m_phase == M_RUN && data_read && m_ok(data_address, DB, DWORDS)) begin
                if (m_dv[m_idx(data_address, DB)])
                    check("data_readdata", data_readdata, m_dmem[m_idx(data_address, DB)]);
            end else begin
                check("data_readdata_zero", data_readdata, 32'h0);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] w [4];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        init_mem      = 1'b0;
        init_mem_addr = RV;
        data_read     = 1'b0;
        data_write    = 1'b0;
        data_address  = DB;
        instr_address = RV;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic do_load(input int n);
        for (int i = 0; i < n; i++) begin
            init_mem      = 1'b1;
            init_mem_addr = RV + 32'(4 * i);
            init_instr    = $urandom;
            w[i]          = init_instr;
            tick();
        end
        init_mem = 1'b0;
        tick();
    endtask

    initial begin
        started = 1'b1;
        // Reset state.
        tick();
        #1;
        check("rst_clk_enable", 32'(clk_enable), 32'h0);
        check("rst_load_count", 32'(load_count), 32'h0);
        check("rst_fault",      32'(fault),      32'h0);
        check("rst_fault_addr", fault_addr,      32'h0);
        reset = 1'b1;
        tick();

        // Load four words and enter RUN.
        do_load(4);
        #1;
        check("load_count_4",    32'(load_count), 32'd4);
        check("run_clk_enable",  32'(clk_enable), 32'h1);
        instr_address = RV + 32'd8;
        #1;
        check("fetch_word2", instr_readdata, w[2]);

        // init_mem in RUN is ignored.
        init_mem      = 1'b1;
        init_mem_addr = RV + 32'd8;
        init_instr    = ~w[2];
        tick();
        init_mem = 1'b0;
        #1;
        check("ignored_init_word2", instr_readdata, w[2]);
        check("ignored_init_count", 32'(load_count), 32'd4);

        // Store then load back.
        data_address   = 32'h10;
        data_write     = 1'b1;
        data_writedata = 32'd7;
        tick();
        data_write = 1'b0;
        data_read  = 1'b1;
        #1;
        check("load_after_store", data_readdata, 32'd7);
        data_read    = 1'b0;
        data_address = 32'h14;
        #1;
        check("no_read_zero", data_readdata, 32'h0);

        // Randomized legal RUN traffic (keeps clear of word 4).
        for (int c = 0; c < 300; c++) begin
            int op;
            op             = int'($urandom_range(0, 2));
            instr_address  = RV + 32'(4 * $urandom_range(0, 3));
            data_address   = 32'h20 + 32'(4 * $urandom_range(0, 15));
            data_writedata = $urandom;
            data_read      = (op == 1);
            data_write     = (op == 2);
            init_mem       = ($urandom_range(0, 7) == 0);
            init_mem_addr  = RV + 32'(4 * $urandom_range(0, 3));
            init_instr     = $urandom;
            tick();
        end
        idle_inputs();
        tick();

        // Misaligned store faults and does not write.
        data_address   = 32'h12;
        data_write     = 1'b1;
        data_writedata = 32'hDEADBEEF;
        tick();
        idle_inputs();
        #1;
        check("misal_fault",      32'(fault),      32'h1);
        check("misal_fault_addr", fault_addr,      32'h12);
        check("misal_clk_enable", 32'(clk_enable), 32'h0);
        tick();
        do_reset();
        do_load(4);
        data_address = 32'h10;
        data_read    = 1'b1;
        #1;
        check("word4_unchanged", data_readdata, 32'd7);
        data_read = 1'b0;

        // Simultaneous read and write.
        data_address = 32'h20;
        data_read    = 1'b1;
        data_write   = 1'b1;
        tick();
        idle_inputs();
        #1;
        check("rw_fault",      32'(fault), 32'h1);
        check("rw_fault_addr", fault_addr, 32'h20);
        do_reset();
        do_load(4);

        // Fetch past the end of instruction memory.
        instr_address = RV + 32'h400;
        tick();
        idle_inputs();
        #1;
        check("fetch_oor_fault_addr", fault_addr,      32'hBFC00400);
        check("fetch_oor_clk_enable", 32'(clk_enable), 32'h0);
        do_reset();

        // Reset during the second load cycle.
        init_mem      = 1'b1;
        init_mem_addr = RV;
        init_instr    = $urandom;
        tick();
        init_mem_addr = RV + 32'd4;
        #2;
        reset = 1'b0;
        #1;
        check("midload_count",      32'(load_count), 32'h0);
        check("midload_clk_enable", 32'(clk_enable), 32'h0);
        tick();
        init_mem = 1'b0;
        reset    = 1'b1;
        tick();
        do_load(4);
        #1;
        check("reload_clk_enable", 32'(clk_enable), 32'h1);
        check("reload_count",      32'(load_count), 32'd4);
        tick();

        started = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_harvard_mem.md
# mips_harvard_mem

Synthesizable instruction and data memory that sits on the memory side of the `mips_cpu_harvard` interface. It responds to CPU instruction fetches and data loads/stores, and gates the CPU's `clk_enable`. Before the CPU runs, the program is loaded word-by-word through an init port. It replaces hand-driven `instr_readdata`/`data_readdata` stimulus in system-level benches, and it traps illegal accesses with a sticky fault.

## Interface
- `INSTR_WORDS`, 256 — instruction memory depth in 32-bit words.
- `DATA_WORDS`, 256 — data memory depth in 32-bit words.
- `RESET_VECTOR`, 32'hBFC00000 — byte address of instruction word 0.
- `DATA_BASE`, 32'h00000000 — byte address of data word 0.

- `clk` in 1 — single clock; all state updates on rising edge.
- `reset` in 1 — asynchronous, active-low reset.
- `init_mem` in 1 — program-load strobe, one word per cycle while high.
- `init_mem_addr` in 32 — byte address of the word being loaded, in the instruction map.
- `init_instr` in 32 — instruction word being loaded.
- `clk_enable` out 1 — to CPU; high only in RUN.
- `instr_active` out 1 — high in RUN; indicates the program is loaded.
- `instr_address` in 32 — CPU fetch byte address.
- `instr_readdata` out 32 — fetched word, combinational.
- `data_address` in 32 — CPU data byte address.
- `data_read` in 1 — load request.
- `data_write` in 1 — store request.
- `data_writedata` in 32 — store data.
- `data_readdata` out 32 — load data, combinational.
- `load_count` out clog2(INSTR_WORDS)+1 — number of words accepted in LOAD.
- `fault` out 1 — sticky illegal-access flag.
- `fault_addr` out 32 — offending address, captured at fault entry.

## Operation
- **Address mapping:**
  - Instruction index = (addr − RESET_VECTOR) >> 2.
  - Data index = (data_address − DATA_BASE) >> 2.
  - Subtraction is 32-bit unsigned modulo.
  - In range means index < depth **and** addr[1:0] == 0.
- **FSM states:** IDLE, LOAD, RUN, FAULT.
- **IDLE:** entered on reset.
  - `init_mem`=1 → LOAD; the first word is written on that same edge.
- **LOAD:** each cycle with `init_mem`=1 writes `init_instr` to the mapped index and increments `load_count`.
  - `init_mem`=0 → RUN.
  - Out-of-range or misaligned `init_mem_addr` → FAULT; `fault_addr` = `init_mem_addr`; no write.
  - `load_count` saturates at INSTR_WORDS.
- **RUN:**
  - `data_write`=1 with in-range address writes `data_writedata` at the clock edge.
  - `data_read` returns `dmem[index]`.
  - `init_mem` is ignored.
  - FAULT entry conditions, evaluated each cycle; the first one met wins, and `fault_addr` captures the corresponding address:
    1. `data_read` && `data_write` in the same cycle → `data_address`;
    2. data access (read or write) out of range or misaligned → `data_address`;
    3. `instr_address` out of range or misaligned → `instr_address`.
  - A faulting store does not write.
- **FAULT:** terminal until reset.
  - `clk_enable`=0, `instr_active`=0, `fault`=1.
  - All writes are blocked.
- **Read-data rules:**
  - `instr_readdata` = `imem[index]` in RUN when in range; otherwise 32'h0 (a NOP).
  - `data_readdata` = `dmem[index]` when in RUN, `data_read`=1, and the access is in range; otherwise 32'h0.
- **Memory contents:** not cleared by reset. Contents are retained across reset; unwritten words are undefined (X in simulation).

## Timing
- **Reset values (asynchronous):** state=IDLE, `clk_enable`=0, `instr_active`=0, `load_count`=0, `fault`=0, `fault_addr`=0.
- **Read latency:** reads are combinational, so zero cycles from address to readdata.
- **Write timing:** writes commit on the rising edge. A read of the same address in the next cycle returns the new value.
- **LOAD→RUN:** the edge on which `init_mem` is sampled low sets state=RUN. `clk_enable` rises right after that edge, so the CPU's first enabled edge is the next one.
- **Fault response:** fault is detected combinationally and registered on the edge. `clk_enable` falls after that edge.
- **Reset mid-LOAD:** returns to IDLE and clears `load_count`. Words already written remain.
- **Reset in FAULT:** the only exit.

## Test plan
- **Load and run:** load 4 words at 0xBFC00000..0xBFC0000C (`init_mem` high for 4 cycles) → `load_count`=4. One cycle after `init_mem` falls, `clk_enable`=1; fetch from 0xBFC00008 returns word 2.
- **Store/load:** in RUN, store 32'd7 to 0x00000010, then next cycle read 0x00000010 → `data_readdata`=7. Read of unwritten-but-in-range 0x14 while `data_read`=0 → 0.
- **Misaligned store:** store to 0x00000012 → `fault`=1, `fault_addr`=0x12, `clk_enable`=0 after the edge, word 4 unchanged.
- **Out-of-range access:** simultaneous `data_read` and `data_write` → FAULT. Separately, fetch from 0xBFC00400 with INSTR_WORDS=256 → FAULT, `fault_addr`=0xBFC00400.
- **Reset mid-load:** assert `reset`=0 during the second load cycle → `load_count`=0, IDLE, `clk_enable`=0. Reload then reaches RUN normally.
- **init_mem in RUN:** `init_mem`=1 while in RUN → ignored; imem unchanged, `load_count` unchanged.
